// File: rtl/chan_ctrl_pkg.sv
// chan_ctrl_pkg: shared state encoding, FFT size constants and config-word layout for the channelizer sequencer
package chan_ctrl_pkg;
  typedef enum logic [2:0] {S_RUN, S_DRAIN, S_RESET, S_FFTWAIT, S_CONFIG} state_t;
  localparam logic [11:0] FFT_8    = 12'd8;
  localparam logic [11:0] FFT_16   = 12'd16;
  localparam logic [11:0] FFT_32   = 12'd32;
  localparam logic [11:0] FFT_64   = 12'd64;
  localparam logic [11:0] FFT_128  = 12'd128;
  localparam logic [11:0] FFT_256  = 12'd256;
  localparam logic [11:0] FFT_512  = 12'd512;
  localparam logic [11:0] FFT_1024 = 12'd1024;
  localparam logic [11:0] FFT_2048 = 12'd2048;
  localparam logic [11:0] DEF_SIZE = FFT_128;
  localparam logic [4:0]  DEF_NFFT = 5'd7;
  localparam int CFG_NFFT_LSB = 0;
  localparam int CFG_NFFT_W   = 5;
  localparam int CFG_FWD_BIT  = 8;
endpackage

// File: rtl/chan_size_decode.sv
// chan_size_decode: maps a host FFT size to a supported size and its log2; unsupported sizes fall back to 2048
module chan_size_decode
  import chan_ctrl_pkg::*;
(
  input  logic [11:0] fft_size,
  output logic        valid,
  output logic [11:0] decoded_size,
  output logic [4:0]  nfft
);
  always_comb begin
    valid = fft_size inside {FFT_8, FFT_16, FFT_32, FFT_64, FFT_128, FFT_256, FFT_512, FFT_1024, FFT_2048};
    decoded_size = valid ? fft_size : FFT_2048;
    nfft = fft_size == FFT_8    ? 5'd3  :
           fft_size == FFT_16   ? 5'd4  :
           fft_size == FFT_32   ? 5'd5  :
           fft_size == FFT_64   ? 5'd6  :
           fft_size == FFT_128  ? 5'd7  :
           fft_size == FFT_256  ? 5'd8  :
           fft_size == FFT_512  ? 5'd9  :
           fft_size == FFT_1024 ? 5'd10 : 5'd11;
  end
endmodule

// File: rtl/chan_reconfig_ctrl.sv
// chan_reconfig_ctrl: gates input, drains, resets the datapath and configures the FFT core on every size change
module chan_reconfig_ctrl
  import chan_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter bit FWD_INV       = 1'b1
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [11:0] fft_size,
  input  logic        dp_idle,
  output logic        in_gate,
  output logic        dp_reset,
  output logic        fft_aresetn,
  output logic [11:0] fft_size_q,
  output logic        cfg_tvalid,
  output logic [15:0] cfg_tdata,
  input  logic        cfg_tready,
  output logic        busy,
  output logic        cfg_done,
  output logic        size_err
);
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [4:0]  nfft;
  logic        dec_valid, trig, latch;
  logic [11:0] dec_size;
  logic [4:0]  dec_nfft;

  chan_size_decode u_dec (
    .fft_size    (fft_size),
    .valid       (dec_valid),
    .decoded_size(dec_size),
    .nfft        (dec_nfft)
  );

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    trig = state == S_RUN && fft_size != '0 && dec_size != fft_size_q;
    case (state)
      S_RUN: begin
        cnt_n = '0;
        state_n = trig ? S_DRAIN : S_RUN;
      end
      S_DRAIN: begin
        cnt_n = cnt + 16'd1;
        if (dp_idle || cnt == 16'(DRAIN_TIMEOUT - 1)) begin
          state_n = S_RESET;
          cnt_n = 16'(RESET_CYCLES - 1);
        end
      end
      S_RESET: begin
        cnt_n = cnt - 16'd1;
        if (cnt == '0) begin
          state_n = S_FFTWAIT;
          cnt_n = 16'd3;
        end
      end
      S_FFTWAIT: begin
        cnt_n = cnt - 16'd1;
        if (cnt == '0) begin
          state_n = S_CONFIG;
          cnt_n = '0;
        end
      end
      S_CONFIG: state_n = cfg_tready ? S_RUN : S_CONFIG;
      default: state_n = S_RESET;
    endcase
    latch = state == S_DRAIN && state_n == S_RESET;
  end

  // outputs are registered from the next state so they change together with the state flop
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_RESET;
      cnt <= 16'(RESET_CYCLES - 1);
      fft_size_q <= DEF_SIZE;
      nfft <= DEF_NFFT;
      in_gate <= 1'b0;
      dp_reset <= 1'b1;
      fft_aresetn <= 1'b0;
      cfg_tvalid <= 1'b0;
      busy <= 1'b1;
      cfg_done <= 1'b0;
      size_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      fft_size_q <= latch ? dec_size : fft_size_q;
      nfft <= latch ? dec_nfft : nfft;
      in_gate <= state_n == S_RUN;
      dp_reset <= state_n == S_RESET || state_n == S_FFTWAIT;
      fft_aresetn <= state_n != S_RESET;
      cfg_tvalid <= state_n == S_CONFIG;
      busy <= state_n != S_RUN;
      cfg_done <= state == S_CONFIG && cfg_tready;
      size_err <= trig && !dec_valid;
    end
  end

  always_comb begin
    cfg_tdata = '0;
    cfg_tdata[CFG_NFFT_LSB +: CFG_NFFT_W] = nfft;
    cfg_tdata[CFG_FWD_BIT] = FWD_INV;
  end
endmodule

// File: tb/tb_chan_reconfig_ctrl.sv
// tb_chan_reconfig_ctrl: directed checks of the reconfiguration sequence, timeouts, handshake stall and async reset
module tb_chan_reconfig_ctrl;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [11:0] fft_size = '0;
  logic        dp_idle = 1'b1;
  logic        cfg_tready = 1'b1;
  logic        in_gate, dp_reset, fft_aresetn, cfg_tvalid, busy, cfg_done, size_err;
  logic [11:0] fft_size_q;
  logic [15:0] cfg_tdata;
  int total = 0;
  int bad = 0;
  int n, rc, tv, viol;
  logic [15:0] td;

  always #5 clk = ~clk;

  chan_reconfig_ctrl dut (
    .clk(clk), .aresetn(aresetn), .fft_size(fft_size), .dp_idle(dp_idle),
    .in_gate(in_gate), .dp_reset(dp_reset), .fft_aresetn(fft_aresetn),
    .fft_size_q(fft_size_q), .cfg_tvalid(cfg_tvalid), .cfg_tdata(cfg_tdata),
    .cfg_tready(cfg_tready), .busy(busy), .cfg_done(cfg_done), .size_err(size_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gate"}, in_gate, 0);
    chk({tag, "_dprst"}, dp_reset, 1);
    chk({tag, "_fftrst"}, fft_aresetn, 0);
    chk({tag, "_tvalid"}, cfg_tvalid, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_size"}, fft_size_q, 128);
    chk({tag, "_tdata"}, cfg_tdata, 16'h0107);
  endtask

  // samples the current cycle onward until in_gate reopens, collecting sequence statistics
  task automatic run_seq();
    n = 0; rc = 0; tv = 0; td = '0;
    while (!in_gate && n < 10000) begin
      if (!fft_aresetn) rc++;
      if (cfg_tvalid) begin tv++; td = cfg_tdata; end
      @(negedge clk);
      n++;
    end
    chk("seq_timeout", n < 10000, 1);
  endtask

  task automatic wait_tvalid();
    n = 0;
    while (!cfg_tvalid && n < 200) begin @(negedge clk); n++; end
    chk("tvalid_timeout", n < 200, 1);
  endtask

  initial begin
    // 1: power-up sequence
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    aresetn = 1'b1;
    run_seq();
    chk("por_len", n, 21);
    chk("por_rstlen", rc, 16);
    chk("por_tvcnt", tv, 1);
    chk("por_tdata", td, 16'h0107);
    chk("por_done", cfg_done, 1);
    chk("por_busy", busy, 0);
    @(negedge clk);
    chk("por_done_pulse", cfg_done, 0);
    chk("por_idle_gate", in_gate, 1);
    // 2: change to 1024 with idle datapath
    fft_size = 12'd1024;
    @(negedge clk);
    chk("s2_gate", in_gate, 0);
    chk("s2_busy", busy, 1);
    chk("s2_serr", size_err, 0);
    run_seq();
    chk("s2_latency", n + 1, 23);
    chk("s2_rstlen", rc, 16);
    chk("s2_tdata", td, 16'h010A);
    chk("s2_size", fft_size_q, 1024);
    // 3: drain timeout with busy datapath
    dp_idle = 1'b0;
    fft_size = 12'd512;
    @(negedge clk);
    chk("s3_gate", in_gate, 0);
    n = 0;
    while (!dp_reset && n < 5000) begin @(negedge clk); n++; end
    chk("s3_timeout", n, 4096);
    chk("s3_size", fft_size_q, 512);
    run_seq();
    chk("s3_tdata", td, 16'h0109);
    // 4: unsupported size
    dp_idle = 1'b1;
    fft_size = 12'd300;
    @(negedge clk);
    chk("s4_serr", size_err, 1);
    @(negedge clk);
    chk("s4_serr_pulse", size_err, 0);
    run_seq();
    chk("s4_size", fft_size_q, 12'd2048);
    chk("s4_tdata", td, 16'h010B);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!in_gate || size_err || busy) viol++;
    end
    chk("s4_no_retrig", viol, 0);
    // 5: config handshake stall
    cfg_tready = 1'b0;
    fft_size = 12'd8;
    wait_tvalid();
    chk("s5_tdata", cfg_tdata, 16'h0103);
    chk("s5_dprst", dp_reset, 0);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!cfg_tvalid || cfg_tdata !== 16'h0103 || in_gate || cfg_done) viol++;
    end
    chk("s5_stall_stable", viol, 0);
    cfg_tready = 1'b1;
    @(negedge clk);
    chk("s5_done", cfg_done, 1);
    chk("s5_tvalid_drop", cfg_tvalid, 0);
    chk("s5_gate", in_gate, 1);
    // 6a: reset during S_RESET
    fft_size = 12'd64;
    n = 0;
    while (fft_aresetn && n < 50) begin @(negedge clk); n++; end
    chk("s6a_reach", n < 50, 1);
    repeat (3) @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk_reset_vals("s6a");
    fft_size = '0;
    @(negedge clk);
    aresetn = 1'b1;
    run_seq();
    chk("s6a_len", n, 21);
    chk("s6a_rstlen", rc, 16);
    chk("s6a_tdata", td, 16'h0107);
    // 6b: reset during S_CONFIG
    cfg_tready = 1'b0;
    fft_size = 12'd256;
    wait_tvalid();
    chk("s6b_tdata", cfg_tdata, 16'h0108);
    aresetn = 1'b0;
    #1;
    chk_reset_vals("s6b");
    fft_size = '0;
    cfg_tready = 1'b1;
    @(negedge clk);
    aresetn = 1'b1;
    run_seq();
    chk("s6b_len", n, 21);
    chk("s6b_tdata", td, 16'h0107);
    chk("s6b_size", fft_size_q, 128);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
